// File: rtl/datamem_param.sv
// Parametrised single-port data memory with byte strobes, req/ready handshake,
// post-reset clear sequence, write acknowledge and out-of-range error reporting.
module datamem_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  ready,
    output logic                  wack,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rerr
);

    localparam int                LANES    = DATA_W / 8;
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic                ready_q;

    logic                accept;
    logic                oor;
    logic                wr_en;
    logic                rd_acc;
    logic [IDX_W-1:0]    idx;

    assign accept = req & ready_q;
    // Full-width compare so addresses beyond DEPTH never alias onto low words.
    assign oor    = ({1'b0, addr} >= DEPTH_L);
    assign wr_en  = accept & we & ~oor;
    assign rd_acc = accept & ~we;
    assign idx    = addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage array and read-data pipeline carry no reset so they map onto block RAM.
    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] dpipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        dpipe_q[0] <= mem_q[idx];
        for (int s = 1; s < RD_LAT; s++) begin
            dpipe_q[s] <= dpipe_q[s-1];
        end
    end

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic              wack_q;
    logic              werr_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rdata_d;

    assign rdata_d = err_q[RD_LAT-1] ? '0 : dpipe_q[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            err_q  <= '0;
            wack_q <= 1'b0;
            werr_q <= 1'b0;
            hold_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            err_q[0] <= rd_acc & oor;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
            end
            wack_q <= accept & we;
            werr_q <= accept & we & oor;
            if (vld_q[RD_LAT-1]) begin
                hold_q <= rdata_d;
            end
        end
    end

    // rdata shows the fresh word during the rvalid cycle and the captured copy after it.
    assign ready  = ready_q;
    assign wack   = wack_q;
    assign rvalid = vld_q[RD_LAT-1];
    assign rdata  = vld_q[RD_LAT-1] ? rdata_d : hold_q;
    assign rerr   = werr_q | (vld_q[RD_LAT-1] & err_q[RD_LAT-1]);

endmodule

// File: tb/tb_datamem_param.sv
// Bench for datamem_param: two instances (read latency 2 and 4, DEPTH 16) share one
// stimulus table; a per-instance scoreboard checks every wack/rvalid/rerr/rdata.
module tb_datamem_param;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        ready_a, wack_a, rvalid_a, rerr_a;
    logic [31:0] rdata_a;
    logic        ready_b, wack_b, rvalid_b, rerr_b;
    logic [31:0] rdata_b;

    datamem_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(DEPTH), .RD_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ready(ready_a), .wack(wack_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .rerr(rerr_a)
    );

    datamem_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(DEPTH), .RD_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ready(ready_b), .wack(wack_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .rerr(rerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t rq0[$], rq1[$], wq0[$], wq1[$];
    logic [31:0] held0 = '0;
    logic [31:0] held1 = '0;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic wk, input logic rv,
                             input logic re, input logic [31:0] rd);
        rsp_t        w, r;
        bit          ew, er;
        logic [31:0] hold;
        string       tag;
        ew  = 0;
        er  = 0;
        tag = (k == 0) ? "lat2" : "lat4";
        if (k == 0) begin
            if (wq0.size() > 0 && wq0[0].due == cyc) begin w = wq0.pop_front(); ew = 1; end
            if (rq0.size() > 0 && rq0[0].due == cyc) begin r = rq0.pop_front(); er = 1; end
            hold = held0;
        end else begin
            if (wq1.size() > 0 && wq1[0].due == cyc) begin w = wq1.pop_front(); ew = 1; end
            if (rq1.size() > 0 && rq1[0].due == cyc) begin r = rq1.pop_front(); er = 1; end
            hold = held1;
        end
        if (ew || wk) chk({tag, " wack"}, 32'(wk), 32'(ew));
        if (er || rv) chk({tag, " rvalid"}, 32'(rv), 32'(er));
        if (er && rv) begin
            chk({tag, " rdata"}, rd, r.data);
            hold = r.data;
        end else if (!rv) begin
            chk({tag, " rdata hold"}, rd, hold);
        end
        if (ew || er || re) chk({tag, " rerr"}, 32'(re), 32'((ew && w.err) || (er && r.err)));
        if (k == 0) held0 = hold; else held1 = hold;
    endtask

    always @(negedge clk) begin
        check_dut(0, wack_a, rvalid_a, rerr_a, rdata_a);
        check_dut(1, wack_b, rvalid_b, rerr_b, rdata_b);
    end

    task automatic chk_idle(input string nm);
        chk({nm, " ready a"}, 32'(ready_a), 0);
        chk({nm, " ready b"}, 32'(ready_b), 0);
        chk({nm, " outs a"}, {28'(0), wack_a, rvalid_a, rerr_a} | rdata_a, 0);
        chk({nm, " outs b"}, {28'(0), wack_b, rvalid_b, rerr_b} | rdata_b, 0);
    endtask

    // Called at a negedge with rst_n low; ready must rise after exactly DEPTH edges.
    task automatic release_and_init();
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            chk($sformatf("init ready a k=%0d", k), 32'(ready_a), 32'(k == DEPTH));
            chk($sformatf("init ready b k=%0d", k), 32'(ready_b), 32'(k == DEPTH));
            if (k == DEPTH) req = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic send(input vec_t v);
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        wstrb = v.wstrb;
        chk("send ready a", 32'(ready_a), 1);
        chk("send ready b", 32'(ready_b), 1);
        @(posedge clk);
        #1;
        if (v.we) begin
            wq0.push_back('{cyc, 32'h0, v.exp_err});
            wq1.push_back('{cyc, 32'h0, v.exp_err});
        end else begin
            rq0.push_back('{cyc + 1, v.exp_rdata, v.exp_err});
            rq1.push_back('{cyc + 3, v.exp_rdata, v.exp_err});
        end
        $display("[TB] cyc %0d %s addr=%h wdata=%h wstrb=%h exp=%h err=%0d",
                 cyc, v.we ? "WR" : "RD", v.addr, v.wdata, v.wstrb, v.exp_rdata, v.exp_err);
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 12'h00F, 32'h0,        4'h0, 32'h00000000, 1'b0};
        tbl[2]  = '{1'b0, 12'h006, 32'h0,        4'h0, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b1, 12'h001, 32'h00001DFE, 4'hF, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 12'h001, 32'h0,        4'h0, 32'h00001DFE, 1'b0};
        tbl[5]  = '{1'b1, 12'h002, 32'h00001EFE, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 12'h002, 32'hAABBCC01, 4'h1, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 12'h002, 32'h0,        4'h0, 32'h00001E01, 1'b0};
        tbl[8]  = '{1'b0, 12'h001, 32'h0,        4'h0, 32'h00001DFE, 1'b0};
        tbl[9]  = '{1'b0, 12'h002, 32'h0,        4'h0, 32'h00001E01, 1'b0};
        tbl[10] = '{1'b0, 12'h001, 32'h0,        4'h0, 32'h00001DFE, 1'b0};
        tbl[11] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h00000000, 1'b0};
        tbl[13] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'h00000000, 1'b1};
        tbl[14] = '{1'b1, 12'h003, 32'h12345678, 4'h0, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 12'h003, 32'h0,        4'h0, 32'h00000000, 1'b0};
        tbl[16] = '{1'b1, 12'hFFF, 32'h00000001, 4'hF, 32'h0,        1'b1};
        tbl[17] = '{1'b0, 12'h100, 32'h0,        4'h0, 32'h00000000, 1'b1};
        tbl[18] = '{1'b1, 12'h004, 32'h11223344, 4'hA, 32'h0,        1'b0};
        tbl[19] = '{1'b0, 12'h004, 32'h0,        4'h0, 32'h11003300, 1'b0};
        tbl[20] = '{1'b1, 12'h00F, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[21] = '{1'b0, 12'h00F, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
        tbl[22] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h00000000, 1'b0};

        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");

        // A write held during INIT must be ignored, not queued.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 12'h006;
        wdata = 32'hFFFFFFFF;
        wstrb = 4'hF;
        release_and_init();

        for (int i = 0; i < 23; i++) send(tbl[i]);
        repeat (6) @(negedge clk);

        // Reset one cycle after a read is accepted: no rvalid, memory re-cleared.
        send('{1'b0, 12'h001, 32'h0, 4'h0, 32'h00001DFE, 1'b0});
        rq0.delete();
        rq1.delete();
        held0 = '0;
        held1 = '0;
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        repeat (2) @(negedge clk);
        chk_idle("midreset hold");
        release_and_init();
        send('{1'b0, 12'h001, 32'h0, 4'h0, 32'h00000000, 1'b0});
        send('{1'b0, 12'h002, 32'h0, 4'h0, 32'h00000000, 1'b0});
        send('{1'b0, 12'h004, 32'h0, 4'h0, 32'h00000000, 1'b0});
        send('{1'b0, 12'h00F, 32'h0, 4'h0, 32'h00000000, 1'b0});
        repeat (8) @(negedge clk);

        chk("drain lat2", 32'(rq0.size() + wq0.size()), 0);
        chk("drain lat4", 32'(rq1.size() + wq1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
